// File: rtl/decode_issue_q.sv
// Decode/issue stage fed by a DEPTH-entry fetch buffer; issues RV32IM instructions to AU/MUL/LSU
// classes and resolves JAL, JALR and conditional branches in-stage with a one-cycle redirect.
module decode_issue_q #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FREE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  input  logic              rs1_valid,
  input  logic              rs2_valid,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [FREE_W-1:0] au_free,
  input  logic [FREE_W-1:0] mul_free,
  input  logic [FREE_W-1:0] lsu_free,
  output logic              issue_valid,
  output logic [16:0]       issue_rd_rs1_rs2,
  output logic [7:0]        issue_execute_type,
  output logic [XLEN-1:0]   issue_imm,
  output logic [XLEN-1:0]   issue_pc,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_addr,
  output logic              jump_wait,
  output logic              illegal
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN = 1'b0, JWAIT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, push, pop, taken_now, need_wait, cls_ok, br_taken;
  logic [31:0]     h_instr;
  logic [XLEN-1:0] h_pc, target;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic            d_au, d_mul, d_lsu, d_ill, d_jal, d_jalr, d_br;
  logic [4:0]      d_op;
  logic [XLEN-1:0] d_imm;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign h_instr = mem_instr[rd_ptr];
  assign h_pc    = mem_pc[rd_ptr];
  assign opc     = h_instr[6:0];
  assign f3      = h_instr[14:12];
  assign f7      = h_instr[31:25];
  assign rs1     = empty ? 5'd0 : h_instr[19:15];
  assign rs2     = empty ? 5'd0 : h_instr[24:20];

  assign imm_i  = {{(XLEN-12){h_instr[31]}}, h_instr[31:20]};
  assign imm_s  = {{(XLEN-12){h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
  assign imm_b  = {{(XLEN-13){h_instr[31]}}, h_instr[31], h_instr[7], h_instr[30:25], h_instr[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){h_instr[31]}}, h_instr[31], h_instr[19:12], h_instr[20], h_instr[30:21], 1'b0};
  assign imm_u  = XLEN'($signed({h_instr[31:12], 12'h000}));
  assign imm_sh = XLEN'(h_instr[24:20]);

  // Head decode: class, execute_op and immediate
  always_comb begin
    d_au = 1'b0; d_mul = 1'b0; d_lsu = 1'b0; d_ill = 1'b0;
    d_jal = 1'b0; d_jalr = 1'b0; d_br = 1'b0;
    d_op = 5'd0; d_imm = '0;
    case (opc)
      7'h33: begin
        if (f7 == 7'h01) begin
          d_mul = 1'b1; d_op = 5'(f3);
        end else if (f7 == 7'h00) begin
          d_au = 1'b1;
          case (f3)
            3'd0: d_op = 5'd0;
            3'd1: d_op = 5'd9;
            3'd2: d_op = 5'd15;
            3'd3: d_op = 5'd17;
            3'd4: d_op = 5'd7;
            3'd5: d_op = 5'd11;
            3'd6: d_op = 5'd5;
            default: d_op = 5'd3;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          d_au = 1'b1; d_op = 5'd2;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          d_au = 1'b1; d_op = 5'd13;
        end else d_ill = 1'b1;
      end
      7'h13: begin
        d_au = 1'b1; d_imm = imm_i;
        case (f3)
          3'd0: d_op = 5'd1;
          3'd2: d_op = 5'd16;
          3'd3: d_op = 5'd18;
          3'd4: d_op = 5'd8;
          3'd6: d_op = 5'd6;
          3'd7: d_op = 5'd4;
          3'd1: begin d_op = 5'd10; d_imm = imm_sh; d_ill = (f7 != 7'h00); end
          default: begin
            d_imm = imm_sh;
            if (f7 == 7'h00) d_op = 5'd12;
            else if (f7 == 7'h20) d_op = 5'd14;
            else d_ill = 1'b1;
          end
        endcase
      end
      7'h37: begin d_au = 1'b1; d_op = 5'd19; d_imm = imm_u; end
      7'h17: begin d_au = 1'b1; d_op = 5'd20; d_imm = imm_u; end
      7'h6F: begin d_jal = 1'b1; d_au = 1'b1; d_op = 5'd21; d_imm = XLEN'(4); end
      7'h67: begin
        d_jalr = 1'b1; d_au = 1'b1; d_op = 5'd21; d_imm = XLEN'(4);
        d_ill = (f3 != 3'd0);
      end
      7'h63: begin d_br = 1'b1; d_ill = (f3 == 3'd2) || (f3 == 3'd3); end
      7'h03: begin
        d_lsu = 1'b1; d_imm = imm_i;
        case (f3)
          3'd0: d_op = 5'd0;
          3'd1: d_op = 5'd1;
          3'd2: d_op = 5'd2;
          3'd4: d_op = 5'd3;
          3'd5: d_op = 5'd4;
          default: d_ill = 1'b1;
        endcase
      end
      7'h23: begin
        d_lsu = 1'b1; d_imm = imm_s;
        case (f3)
          3'd0: d_op = 5'd5;
          3'd1: d_op = 5'd6;
          3'd2: d_op = 5'd7;
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_au = 1'b0; d_mul = 1'b0; d_lsu = 1'b0;
      d_jal = 1'b0; d_jalr = 1'b0; d_br = 1'b0;
    end
  end

  // Branch condition on the presented operands
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'd0: br_taken = (rs1_data == rs2_data);
      3'd1: br_taken = (rs1_data != rs2_data);
      3'd4: br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'd5: br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'd6: br_taken = (rs1_data <  rs2_data);
      3'd7: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  assign cls_ok = (d_au && au_free != '0) || (d_mul && mul_free != '0) || (d_lsu && lsu_free != '0);

  // Pop / jump resolution; in JWAIT the head is always the waiting jump
  always_comb begin
    pop = 1'b0; taken_now = 1'b0; need_wait = 1'b0; target = '0;
    if (!empty && !flush) begin
      if (d_ill) begin
        pop = (state == RUN);
      end else if (d_jal) begin
        pop = (state == RUN) && (au_free != '0);
        taken_now = pop;
        target = h_pc + imm_j;
      end else if (d_jalr) begin
        pop = rs1_valid && (au_free != '0);
        taken_now = pop;
        need_wait = !rs1_valid;
        target = (rs1_data + imm_i) & ~XLEN'(1);
      end else if (d_br) begin
        pop = rs1_valid && rs2_valid;
        taken_now = pop && br_taken;
        need_wait = !pop;
        target = h_pc + imm_b;
      end else begin
        pop = (state == RUN) && cls_ok;
      end
    end
  end

  assign in_ready  = !full && !flush && !taken_now;
  assign push      = in_valid && in_ready;
  assign jump_wait = (state == JWAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = RUN;
    else begin
      case (state)
        RUN:     if (need_wait) state_nxt = JWAIT;
        JWAIT:   if (pop) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Buffer pointers; a flush or taken jump empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else if (flush || taken_now) begin
      rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0; issue_rd_rs1_rs2 <= '0; issue_execute_type <= '0;
      issue_imm <= '0; issue_pc <= '0; redirect <= 1'b0; redirect_addr <= '0; illegal <= 1'b0;
    end else begin
      issue_valid <= pop && (d_au || d_mul || d_lsu);
      illegal     <= pop && d_ill;
      redirect    <= taken_now;
      if (pop && (d_au || d_mul || d_lsu)) begin
        issue_rd_rs1_rs2   <= {h_instr[11:7], rs1_valid, h_instr[19:15], rs2_valid, h_instr[24:20]};
        issue_execute_type <= {d_au, d_mul, d_lsu, d_op};
        issue_imm          <= d_imm;
        issue_pc           <= h_pc;
      end
      if (taken_now) redirect_addr <= target;
    end
  end

endmodule

// File: tb/tb_decode_issue_q.sv
// Bench for decode_issue_q: directed jump/flush/reset scenarios and a randomized run
// against a queue model built from mnemonic-level expectations.
module tb_decode_issue_q;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned FREE_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic [4:0]        rs1, rs2;
  logic              rs1_valid, rs2_valid;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [FREE_W-1:0] au_free, mul_free, lsu_free;
  logic              issue_valid, redirect, jump_wait, illegal;
  logic [16:0]       issue_rd_rs1_rs2;
  logic [7:0]        issue_execute_type;
  logic [XLEN-1:0]   issue_imm, issue_pc, redirect_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_issue_q #(.XLEN(XLEN), .DEPTH(DEPTH), .FREE_W(FREE_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .rs1(rs1), .rs2(rs2), .rs1_valid(rs1_valid),
    .rs2_valid(rs2_valid), .rs1_data(rs1_data), .rs2_data(rs2_data), .au_free(au_free),
    .mul_free(mul_free), .lsu_free(lsu_free), .issue_valid(issue_valid),
    .issue_rd_rs1_rs2(issue_rd_rs1_rs2), .issue_execute_type(issue_execute_type),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .redirect(redirect),
    .redirect_addr(redirect_addr), .jump_wait(jump_wait), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    int          cls;    // 0 illegal, 1 AU, 2 MUL, 3 LSU
    logic [4:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
  } ent_t;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, s2, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  // Random instruction drawn by mnemonic, with its architectural expectations
  function automatic ent_t gen_rand();
    ent_t e;
    logic [4:0]  rd, s1, s2, sh;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [2:0]  f3;
    rd = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); sh = 5'($urandom);
    i12 = 12'($urandom); u20 = 20'($urandom); f3 = 3'($urandom);
    e.cls = 1; e.op = 5'd0; e.imm = 32'd0; e.pc = 32'd0;
    case ($urandom_range(0, 11))
      0: begin e.instr = enc_i(i12, s1, 3'd0, rd, 7'h13); e.op = 5'd1; e.imm = {{20{i12[11]}}, i12}; end
      1: begin e.instr = enc_r(7'h00, s2, s1, 3'd0, rd, 7'h33); e.op = 5'd0; end
      2: begin e.instr = enc_r(7'h20, s2, s1, 3'd0, rd, 7'h33); e.op = 5'd2; end
      3: begin e.instr = enc_r(7'h01, s2, s1, f3, rd, 7'h33); e.cls = 2; e.op = 5'(f3); end
      4: begin e.instr = enc_i(i12, s1, 3'd2, rd, 7'h03); e.cls = 3; e.op = 5'd2; e.imm = {{20{i12[11]}}, i12}; end
      5: begin e.instr = {i12[11:5], s2, s1, 3'd2, i12[4:0], 7'h23}; e.cls = 3; e.op = 5'd7; e.imm = {{20{i12[11]}}, i12}; end
      6: begin e.instr = {u20, rd, 7'h37}; e.op = 5'd19; e.imm = {u20, 12'h000}; end
      7: begin e.instr = enc_r(7'h20, sh, s1, 3'd5, rd, 7'h13); e.op = 5'd14; e.imm = 32'(sh); end
      8: begin e.instr = enc_r(7'h00, s2, s1, 3'd3, rd, 7'h33); e.op = 5'd17; end
      9: begin e.instr = {25'($urandom), 7'h7F}; e.cls = 0; end
      10: begin e.instr = enc_i(i12, s1, 3'd4, rd, 7'h03); e.cls = 3; e.op = 5'd3; e.imm = {{20{i12[11]}}, i12}; end
      default: begin e.instr = enc_b(13'(i12), s2, s1, 3'd2); e.cls = 0; end
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got=%0b exp=0", issue_valid); end
    total++; if (redirect_addr !== 32'd0) begin bad++; $display("FAIL rst_redirect_addr got=%h exp=0", redirect_addr); end
    total++; if ({redirect, illegal, jump_wait} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {redirect, illegal, jump_wait}); end
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    au_free = '0;
    for (int i = 0; i < 3; i++) push_one(enc_i(12'(i), 5'd3, 3'd0, 5'd4, 7'h13), 32'h10 + 32'(4 * i));
    total++; if (rs1 !== 5'd3) begin bad++; $display("FAIL rst_head_rs1 got=%0d exp=3", rs1); end
    au_free = 3'd1;
    tick();
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_issue got=%0b exp=1", issue_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_async_issue got=%0b exp=0", issue_valid); end
    total++; if (issue_execute_type !== 8'h00) begin bad++; $display("FAIL rst_async_type got=%h exp=00", issue_execute_type); end
    total++; if (rs1 !== 5'd0) begin bad++; $display("FAIL rst_async_rs1 got=%0d exp=0", rs1); end
    tick();
    rst = 1'b0; au_free = 3'd2; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b exp=1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rst_no_issue cyc=%0d got=%0b exp=0", i, issue_valid); end
    end
    au_free = '0;
  endtask

  task automatic test_fill();
    au_free = '0;
    for (int i = 0; i < 2; i++) push_one(enc_i(12'(50 + i), 5'd1, 3'd0, 5'd2, 7'h13), 32'h30 + 32'(4 * i));
    au_free = 3'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (issue_imm !== 32'(50 + i)) begin bad++; $display("FAIL fill_pre_imm i=%0d got=%0d exp=%0d", i, issue_imm, 50 + i); end
    end
    au_free = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      push_one(enc_i(12'(100 + i), 5'd1, 3'd0, 5'd2, 7'h13), 32'h40 + 32'(4 * i));
      total++; if (in_ready !== (i < 3)) begin bad++; $display("FAIL fill_in_ready i=%0d got=%0b exp=%0b", i, in_ready, i < 3); end
    end
    au_free = 3'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL fill_issue_valid i=%0d got=%0b exp=1", i, issue_valid); end
      total++; if (issue_execute_type !== 8'h81) begin bad++; $display("FAIL fill_type i=%0d got=%h exp=81", i, issue_execute_type); end
      total++; if (issue_imm !== 32'(100 + i)) begin bad++; $display("FAIL fill_imm i=%0d got=%0d exp=%0d", i, issue_imm, 100 + i); end
      total++; if (issue_pc !== 32'h40 + 32'(4 * i)) begin bad++; $display("FAIL fill_pc i=%0d got=%h exp=%h", i, issue_pc, 32'h40 + 32'(4 * i)); end
    end
    tick();
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL fill_drained got=%0b exp=0", issue_valid); end
    au_free = '0;
  endtask

  task automatic test_jal();
    logic [31:0] addi;
    addi = enc_i(12'd7, 5'd9, 3'd0, 5'd9, 7'h13);
    au_free = '0;
    push_one(enc_j(21'h20, 5'd1), 32'h100);
    push_one(addi, 32'h104);
    push_one(addi, 32'h108);
    in_valid = 1'b1; in_pc = 32'h10C; in_instr = addi; au_free = 3'd1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL jal_in_ready got=%0b exp=0", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL jal_redirect got=%0b exp=1", redirect); end
    total++; if (redirect_addr !== 32'h120) begin bad++; $display("FAIL jal_addr got=%h exp=120", redirect_addr); end
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL jal_issue got=%0b exp=1", issue_valid); end
    total++; if (issue_execute_type !== 8'h95) begin bad++; $display("FAIL jal_type got=%h exp=95", issue_execute_type); end
    total++; if (issue_imm !== 32'd4) begin bad++; $display("FAIL jal_imm got=%h exp=4", issue_imm); end
    total++; if (issue_pc !== 32'h100) begin bad++; $display("FAIL jal_pc got=%h exp=100", issue_pc); end
    total++; if (issue_rd_rs1_rs2[16:12] !== 5'd1) begin bad++; $display("FAIL jal_rd got=%0d exp=1", issue_rd_rs1_rs2[16:12]); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({issue_valid, redirect} !== 2'b00) begin bad++; $display("FAIL jal_discard cyc=%0d got=%b exp=00", i, {issue_valid, redirect}); end
    end
    au_free = '0;
  endtask

  task automatic test_branch();
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; rs1_valid = 1'b1; rs2_valid = 1'b0;
    push_one(enc_b(13'h040, 5'd2, 5'd1, 3'd4), 32'h200);
    total++; if ({rs1, rs2} !== {5'd1, 5'd2}) begin bad++; $display("FAIL blt_head_rs got=%0d/%0d exp=1/2", rs1, rs2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({jump_wait, redirect} !== 2'b10) begin bad++; $display("FAIL blt_wait cyc=%0d got=%b exp=10", i, {jump_wait, redirect}); end
    end
    rs2_valid = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL blt_in_ready got=%0b exp=0", in_ready); end
    tick();
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL blt_redirect got=%0b exp=1", redirect); end
    total++; if (redirect_addr !== 32'h240) begin bad++; $display("FAIL blt_addr got=%h exp=240", redirect_addr); end
    total++; if ({jump_wait, issue_valid} !== 2'b00) begin bad++; $display("FAIL blt_after got=%b exp=00", {jump_wait, issue_valid}); end
    push_one(enc_b(13'h040, 5'd2, 5'd1, 3'd6), 32'h300);
    tick();
    total++; if ({redirect, issue_valid, jump_wait} !== 3'b000) begin bad++; $display("FAIL bltu_flags got=%b exp=000", {redirect, issue_valid, jump_wait}); end
    total++; if (rs1 !== 5'd0) begin bad++; $display("FAIL bltu_popped got=%0d exp=0", rs1); end
    total++; if (redirect_addr !== 32'h240) begin bad++; $display("FAIL bltu_addr_hold got=%h exp=240", redirect_addr); end
  endtask

  task automatic test_jalr();
    logic [31:0] d [2];
    logic [11:0] im [2];
    logic [31:0] ex [2];
    d[0] = 32'h203;  im[0] = 12'h000; ex[0] = 32'h202;
    d[1] = 32'h1001; im[1] = 12'hFFC; ex[1] = 32'hFFC;
    au_free = 3'd1;
    for (int i = 0; i < 2; i++) begin
      rs1_data = d[i]; rs1_valid = (i == 0);
      push_one(enc_i(im[i], 5'd5, 3'd0, 5'd1, 7'h67), 32'h400 + 32'(16 * i));
      if (i == 1) begin
        tick();
        total++; if ({jump_wait, issue_valid, redirect} !== 3'b100) begin bad++; $display("FAIL jalr_wait got=%b exp=100", {jump_wait, issue_valid, redirect}); end
        rs1_valid = 1'b1;
      end
      tick();
      total++; if (redirect !== 1'b1) begin bad++; $display("FAIL jalr_redirect i=%0d got=%0b exp=1", i, redirect); end
      total++; if (redirect_addr !== ex[i]) begin bad++; $display("FAIL jalr_addr i=%0d got=%h exp=%h", i, redirect_addr, ex[i]); end
      total++; if (issue_execute_type !== 8'h95 || issue_valid !== 1'b1) begin bad++; $display("FAIL jalr_issue i=%0d got=%h/%0b exp=95/1", i, issue_execute_type, issue_valid); end
      total++; if (issue_pc !== 32'h400 + 32'(16 * i)) begin bad++; $display("FAIL jalr_pc i=%0d got=%h exp=%h", i, issue_pc, 32'h400 + 32'(16 * i)); end
    end
    au_free = '0;
  endtask

  task automatic test_flush_branch();
    logic [31:0] addi;
    addi = enc_i(12'd3, 5'd6, 3'd0, 5'd6, 7'h13);
    au_free = 3'd1; rs1_valid = 1'b0; rs2_valid = 1'b1; rs1_data = 32'd5; rs2_data = 32'd5;
    push_one(enc_b(13'h010, 5'd2, 5'd1, 3'd0), 32'h500);
    push_one(addi, 32'h504);
    total++; if (jump_wait !== 1'b1) begin bad++; $display("FAIL flush_pre_wait got=%0b exp=1", jump_wait); end
    rs1_valid = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h508; in_instr = addi; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    total++; if ({redirect, issue_valid, jump_wait} !== 3'b000) begin bad++; $display("FAIL flush_flags got=%b exp=000", {redirect, issue_valid, jump_wait}); end
    total++; if ({rs1, in_ready} !== 6'b000001) begin bad++; $display("FAIL flush_empty got=%0d/%0b exp=0/1", rs1, in_ready); end
    tick();
    total++; if ({redirect, issue_valid} !== 2'b00) begin bad++; $display("FAIL flush_after got=%b exp=00", {redirect, issue_valid}); end
    au_free = '0;
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t nx, hd;
    logic [31:0] pc;
    logic popped, exp_ready, rv1, rv2;
    logic [4:0] exp_rs1;
    pc = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      nx = gen_rand();
      nx.pc = pc;
      in_valid = (cyc < 380) && ($urandom_range(0, 2) != 0);
      in_instr = nx.instr; in_pc = pc;
      au_free  = (cyc >= 380 || $urandom_range(0, 2) != 0) ? FREE_W'($urandom_range(1, 7)) : '0;
      mul_free = (cyc >= 380 || $urandom_range(0, 2) != 0) ? FREE_W'($urandom_range(1, 7)) : '0;
      lsu_free = (cyc >= 380 || $urandom_range(0, 2) != 0) ? FREE_W'($urandom_range(1, 7)) : '0;
      rs1_valid = 1'($urandom); rs2_valid = 1'($urandom);
      rv1 = rs1_valid; rv2 = rs2_valid;
      #1;
      exp_ready = (q.size() < DEPTH);
      exp_rs1 = (q.size() > 0) ? q[0].instr[19:15] : 5'd0;
      total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready); end
      total++; if (rs1 !== exp_rs1) begin bad++; $display("FAIL rand_rs1 cyc=%0d got=%0d exp=%0d", cyc, rs1, exp_rs1); end
      popped = 1'b0;
      if (q.size() > 0) begin
        hd = q[0];
        case (hd.cls)
          0: popped = 1'b1;
          1: popped = (au_free != '0);
          2: popped = (mul_free != '0);
          default: popped = (lsu_free != '0);
        endcase
        if (popped) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        q.push_back(nx);
        pc += 32'd4;
      end
      tick();
      total++; if (issue_valid !== (popped && hd.cls != 0)) begin bad++; $display("FAIL rand_issue_valid cyc=%0d got=%0b exp=%0b", cyc, issue_valid, popped && hd.cls != 0); end
      total++; if (illegal !== (popped && hd.cls == 0)) begin bad++; $display("FAIL rand_illegal cyc=%0d got=%0b exp=%0b", cyc, illegal, popped && hd.cls == 0); end
      if (popped && hd.cls != 0) begin
        total++; if (issue_execute_type !== {hd.cls == 1, hd.cls == 2, hd.cls == 3, hd.op}) begin bad++; $display("FAIL rand_type cyc=%0d got=%h exp=%h", cyc, issue_execute_type, {hd.cls == 1, hd.cls == 2, hd.cls == 3, hd.op}); end
        total++; if (issue_imm !== hd.imm) begin bad++; $display("FAIL rand_imm cyc=%0d got=%h exp=%h", cyc, issue_imm, hd.imm); end
        total++; if (issue_pc !== hd.pc) begin bad++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", cyc, issue_pc, hd.pc); end
        total++; if (issue_rd_rs1_rs2 !== {hd.instr[11:7], rv1, hd.instr[19:15], rv2, hd.instr[24:20]}) begin
          bad++; $display("FAIL rand_regs cyc=%0d got=%h exp=%h", cyc, issue_rd_rs1_rs2, {hd.instr[11:7], rv1, hd.instr[19:15], rv2, hd.instr[24:20]});
        end
      end
    end
    total++; if (q.size() != 0 || rs1 !== 5'd0) begin bad++; $display("FAIL rand_drain got=%0d entries exp=0", q.size()); end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0;
    rs1_valid = 1'b0; rs2_valid = 1'b0; rs1_data = '0; rs2_data = '0;
    au_free = '0; mul_free = '0; lsu_free = '0;
    test_reset();
    test_fill();
    test_jal();
    test_branch();
    test_jalr();
    test_flush_branch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_q.md
Name: decode_issue_q

Overview:
- Parametrised successor to the single-instruction decode stage. Adds a DEPTH-entry fetch buffer with valid/ready input handshake.
- Decodes the RV32IM instruction at the buffer head and issues it to the AU, MUL or LSU class when that class has a free slot.
- Resolves JAL, JALR and conditional branches in-stage. Any taken jump issues a one-cycle redirect and flushes the buffer.
- Sits between fetch and the reservation stations/register-status logic.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, fetch buffer entries (power of 2, >=2)
FREE_W, 3, width of per-class free-slot counts

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  fetch beat valid
in_ready  out  1  buffer can accept beat
in_pc  in  XLEN  pc of fetched instruction
in_instr  in  32  fetched instruction
flush  in  1  external pipeline flush
rs1  out  5  head rs1 index (0 when buffer empty)
rs2  out  5  head rs2 index (0 when buffer empty)
rs1_valid  in  1  rs1 operand available
rs2_valid  in  1  rs2 operand available
rs1_data  in  XLEN  rs1 operand
rs2_data  in  XLEN  rs2 operand
au_free  in  FREE_W  free AU slots
mul_free  in  FREE_W  free MUL slots
lsu_free  in  FREE_W  free LSU slots
issue_valid  out  1  issue bundle valid (one-cycle pulse per instruction)
issue_rd_rs1_rs2  out  17  {rd, rs1_valid, rs1, rs2_valid, rs2}
issue_execute_type  out  8  {au, mul, lsu, op[4:0]}
issue_imm  out  XLEN  sign/zero-extended immediate
issue_pc  out  XLEN  pc of issued instruction
redirect  out  1  one-cycle taken-jump pulse
redirect_addr  out  XLEN  jump target
jump_wait  out  1  stalled waiting for branch/jalr operands
illegal  out  1  one-cycle pulse: unsupported opcode/funct popped

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- On reset: buffer empty, state RUN, and every registered output is 0.
- Buffer:
  - Circular FIFO with read/write pointers and a count.
  - in_ready = !full & !flush & !taken_now, where taken_now is a same-cycle taken jump.
  - Push on in_valid & in_ready. Push and pop in the same cycle keep count unchanged.
- execute_op encoding (unchanged from the current decode):
  - AU: add 0, addi 1, sub 2, and 3, andi 4, or 5, ori 6, xor 7, xori 8, sll 9, slli 10, srl 11, srli 12, sra 13, srai 14, slt 15, slti 16, sltu 17, sltiu 18, lui 19, auipc 20, jal/jalr link 21.
  - MUL: op = funct3.
  - LSU: lb 0, lh 1, lw 2, lbu 3, lhu 4, sb 5, sh 6, sw 7.
- Immediates:
  - I, S, B, J types are sign-extended to XLEN.
  - U type is {imm[31:12], 12'b0}.
  - Shift-immediates are zero-extended shamt.
- Issue: the head pops when its class free count != 0 and state is RUN.
  - The issue_* outputs register the head, so latency is 1 cycle from pop to issue_valid.
  - If the class is not free, the head holds and nothing is issued.
- JAL:
  - Always issues to AU (op 21, imm = 4) for the link.
  - Pops when AU is free. In the same cycle: redirect = 1 and redirect_addr = pc + J-imm, registered next cycle. The FIFO clears and the in-beat is dropped.
- JALR:
  - If rs1_valid and AU is free: target = (rs1_data + I-imm) & ~1, handled like JAL.
  - If rs1 is not valid: enter JWAIT and assert jump_wait. Stay until rs1_valid, then resolve.
- Branch (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - Needs both operands valid, otherwise JWAIT. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
  - Taken: redirect to pc + B-imm and flush.
  - Not taken: pop silently.
  - No FU issue and no issue_valid in either case.
- States: RUN, JWAIT. Transitions:
  - RUN -> JWAIT when the head is a jalr/branch with missing operands.
  - JWAIT -> RUN on resolve or flush.
- Illegal: an unknown opcode or reserved funct pops with illegal = 1 and no issue.
- flush:
  - Clears the FIFO and forces RUN. issue_valid, redirect and illegal are 0 in the next cycle.
  - flush wins over push, pop and redirect in the same cycle.
- Pointer wrap: modulo DEPTH, and count saturates exactly at DEPTH.

Test Plan:
- Reset mid-run with 3 entries buffered: assert rst -> outputs 0 immediately, in_ready = 1 after release, no issue_valid.
- Fill with 4 ADDIs while au_free = 0 -> in_ready = 0 after the 4th beat. Then au_free = 2 -> four consecutive issue_valid pulses with op 1, in order, and pointers wrap correctly.
- JAL at pc 0x100, imm +0x20, with 2 younger entries buffered -> redirect = 1 with addr 0x120, AU issue with op 21, younger entries discarded, and the same-cycle in-beat dropped.
- BLT x1,x2 with rs1 = 0xFFFFFFFF, rs2 = 1, rs2_valid low for 3 cycles -> jump_wait high 3 cycles, then taken redirect. BLTU with the same operands -> not taken, no redirect.
- JALR with rs1_data = 0x203, imm 0 -> redirect_addr = 0x202.
- Flush asserted the same cycle as a taken branch and an in-beat -> no redirect, buffer empty, state RUN.
